// File: rtl/unidade_load_store_pkg.sv
// Shared definitions for the load/store unit: operation codes, FSM states
// and the request decoding helpers used at request acceptance.
package unidade_load_store_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        ACESSO    = 2'd1,
        ESCRITA   = 2'd2,
        CONCLUIDO = 2'd3
    } estado_t;

    localparam int PROFUNDIDADE_PADRAO = 31;

    function automatic logic eh_carga(input op_t op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    // Words need 4-byte alignment, halves 2-byte; bytes never fault here.
    function automatic logic desalinhado(input op_t op, input logic [1:0] faixa);
        logic r;
        r = 1'b0;
        case (op)
            OP_LW, OP_SW:          r = |faixa;
            OP_LH, OP_LHU, OP_SH:  r = faixa[0];
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/unidade_load_store_alinha_subpalavra.sv
// Combinational lane logic: big-endian extraction with sign/zero extension
// for loads, and lane replacement of the old word for SH/SB.
module alinha_subpalavra
    import unidade_load_store_pkg::*;
(
    input  op_t         op,
    input  logic [1:0]  faixa,
    input  logic [31:0] palavra,
    input  logic [15:0] dado,
    output logic [31:0] carga,
    output logic [31:0] mescla
);

    logic [7:0]  lane [4];
    logic [15:0] meia_sel;
    logic [7:0]  byte_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_faixa
            localparam int ALTO = 31 - 8 * gi;
            logic       sel;
            logic [7:0] novo;

            assign lane[gi] = palavra[ALTO -: 8];
            // SH covers lanes {0,1} or {2,3}; even lane of a half takes the high byte.
            assign sel  = (op == OP_SB) ? (faixa == 2'(gi))
                        : ((op == OP_SH) && (faixa[1] == 1'(gi / 2)));
            assign novo = ((op == OP_SB) || ((gi % 2) == 1)) ? dado[7:0] : dado[15:8];
            assign mescla[ALTO -: 8] = sel ? novo : lane[gi];
        end
    endgenerate

    assign byte_sel = lane[faixa];
    assign meia_sel = faixa[1] ? palavra[15:0] : palavra[31:16];

    always_comb begin
        carga = palavra;
        case (op)
            OP_LH:   carga = {{16{meia_sel[15]}}, meia_sel};
            OP_LHU:  carga = {16'h0000, meia_sel};
            OP_LB:   carga = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  carga = {24'h000000, byte_sel};
            default: carga = palavra;
        endcase
    end

endmodule

// File: rtl/unidade_load_store.sv
// Load/store unit in front of memoria_de_dados: converts byte-addressed CPU
// requests into word accesses, with read-modify-write for SH/SB.
module unidade_load_store
    import unidade_load_store_pkg::*;
#(
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] endereco,
    input  logic [31:0] dado_Escrito,
    output logic [31:0] dado_Lido,
    output logic        pronto,
    output logic        erro,
    output logic        ocupado,
    output logic [25:0] mem_endereco,
    output logic        mem_memWrite,
    output logic [31:0] mem_dado_Escrito,
    input  logic [31:0] mem_dado_Lido
);

    estado_t     estado_q, estado_d;
    op_t         op_q, op_d;
    logic [27:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] mescla_q, mescla_d;
    logic [31:0] dado_q, dado_d;
    logic        erro_q, erro_d;

    logic        escreve_c;
    logic [31:0] wdata_c;
    logic [31:0] carga_c;
    logic [31:0] mescla_c;
    logic        falha_c;
    logic        unused_bits;

    // The top nibble of the byte address is outside memoria_de_dados' map.
    assign unused_bits = ^endereco[31:28];

    assign falha_c = desalinhado(op_t'(op), endereco[1:0]) ||
                     ({6'b0, endereco[27:2]} >= 32'(PROFUNDIDADE));

    alinha_subpalavra u_alinha (
        .op      (op_q),
        .faixa   (addr_q[1:0]),
        .palavra (mem_dado_Lido),
        .dado    (data_q[15:0]),
        .carga   (carga_c),
        .mescla  (mescla_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
            op_q     <= OP_LW;
            addr_q   <= '0;
            data_q   <= '0;
            mescla_q <= '0;
            dado_q   <= '0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            mescla_q <= mescla_d;
            dado_q   <= dado_d;
            erro_q   <= erro_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        mescla_d  = mescla_q;
        dado_d    = dado_q;
        erro_d    = erro_q;
        escreve_c = 1'b0;
        wdata_c   = '0;
        case (estado_q)
            OCIOSO: begin
                if (req) begin
                    op_d   = op_t'(op);
                    addr_d = endereco[27:0];
                    data_d = dado_Escrito;
                    if (falha_c) begin
                        estado_d = CONCLUIDO;
                        erro_d   = 1'b1;
                        dado_d   = '0;
                    end else begin
                        estado_d = ACESSO;
                    end
                end
            end
            ACESSO: begin
                if (eh_carga(op_q)) begin
                    dado_d   = carga_c;
                    erro_d   = 1'b0;
                    estado_d = CONCLUIDO;
                end else if (op_q == OP_SW) begin
                    escreve_c = 1'b1;
                    wdata_c   = data_q;
                    dado_d    = '0;
                    erro_d    = 1'b0;
                    estado_d  = CONCLUIDO;
                end else begin
                    mescla_d = mescla_c;
                    estado_d = ESCRITA;
                end
            end
            ESCRITA: begin
                escreve_c = 1'b1;
                wdata_c   = mescla_q;
                dado_d    = '0;
                erro_d    = 1'b0;
                estado_d  = CONCLUIDO;
            end
            CONCLUIDO: estado_d = OCIOSO;
            default:   estado_d = OCIOSO;
        endcase
    end

    // Reset must suppress a write even on the edge it interrupts.
    assign mem_memWrite     = escreve_c & ~reset;
    assign mem_dado_Escrito = wdata_c;
    assign mem_endereco     = addr_q[27:2];
    assign dado_Lido        = dado_q;
    assign erro             = erro_q;
    assign pronto           = (estado_q == CONCLUIDO);
    assign ocupado          = (estado_q != OCIOSO);

endmodule

// File: tb/tb_unidade_load_store.sv
// Directed and random bench for unidade_load_store with an attached word memory
// and an arithmetic reference model of the byte-addressed memory semantics.
module tb_unidade_load_store;

    localparam int PROF = 31;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic [2:0]  op;
    logic [31:0] endereco;
    logic [31:0] dado_Escrito;
    logic [31:0] dado_Lido;
    logic        pronto;
    logic        erro;
    logic        ocupado;
    logic [25:0] mem_endereco;
    logic        mem_memWrite;
    logic [31:0] mem_dado_Escrito;
    logic [31:0] mem_dado_Lido;

    logic [31:0] mem     [0:PROF-1];
    logic [31:0] ref_mem [0:PROF-1];
    int          n_writes = 0;
    logic [25:0] last_wr  = '0;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clock = ~clock;

    unidade_load_store #(.PROFUNDIDADE(PROF)) dut (
        .clock            (clock),
        .reset            (reset),
        .req              (req),
        .op               (op),
        .endereco         (endereco),
        .dado_Escrito     (dado_Escrito),
        .dado_Lido        (dado_Lido),
        .pronto           (pronto),
        .erro             (erro),
        .ocupado          (ocupado),
        .mem_endereco     (mem_endereco),
        .mem_memWrite     (mem_memWrite),
        .mem_dado_Escrito (mem_dado_Escrito),
        .mem_dado_Lido    (mem_dado_Lido)
    );

    assign mem_dado_Lido = (mem_endereco < 26'(PROF)) ? mem[mem_endereco[4:0]] : 32'h0;

    always @(posedge clock) begin
        if (mem_memWrite) begin
            if (mem_endereco < 26'(PROF)) mem[mem_endereco[4:0]] <= mem_dado_Escrito;
            n_writes <= n_writes + 1;
            last_wr  <= mem_endereco;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed big-endian memory semantics in plain arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                         output logic e, output logic [31:0] rd, output int lat, output int nw);
        int          w;
        int          b;
        int          sh;
        logic        mis;
        logic [31:0] word;
        logic [31:0] v;
        w   = int'(a[27:2]);
        b   = int'(a[1:0]);
        mis = ((o == LW || o == SW) && b != 0) ||
              ((o == LH || o == LHU || o == SH) && (b % 2) != 0);
        rd  = 32'h0;
        e   = 1'b0;
        nw  = 0;
        lat = 2;
        if (mis || w >= PROF) begin
            e   = 1'b1;
            lat = 1;
        end else begin
            word = ref_mem[w];
            case (o)
                LW: rd = word;
                LH, LHU: begin
                    sh = (b >= 2) ? 0 : 16;
                    v  = (word >> sh) & 32'hFFFF;
                    if (o == LH && v >= 32'h8000) v = v | 32'hFFFF0000;
                    rd = v;
                end
                LB, LBU: begin
                    sh = 24 - 8 * b;
                    v  = (word >> sh) & 32'hFF;
                    if (o == LB && v >= 32'h80) v = v | 32'hFFFFFF00;
                    rd = v;
                end
                SW: begin
                    ref_mem[w] = d;
                    nw = 1;
                end
                SH: begin
                    sh = (b >= 2) ? 0 : 16;
                    ref_mem[w] = (word & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
                    nw = 1;
                    lat = 3;
                end
                default: begin
                    sh = 24 - 8 * b;
                    ref_mem[w] = (word & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
                    nw = 1;
                    lat = 3;
                end
            endcase
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        logic        e_exp;
        logic [31:0] rd_exp;
        int          lat_exp;
        int          nw_exp;
        int          w0;
        int          lat;
        model(o, a, d, e_exp, rd_exp, lat_exp, nw_exp);
        @(negedge clock);
        req = 1'b1; op = o; endereco = a; dado_Escrito = d;
        w0 = n_writes;
        @(posedge clock); #1;
        req = 1'b0;
        lat = 1;
        while (pronto !== 1'b1 && lat < 8) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(lat_exp));
        chk("erro", {31'b0, erro}, {31'b0, e_exp});
        if (o <= LBU || e_exp) chk("dado_Lido", dado_Lido, rd_exp);
        chk("writes", 32'(n_writes - w0), 32'(nw_exp));
        $display("op=%0d addr=%h data=%h -> erro=%0b dado_Lido=%h latency=%0d",
                 o, a, d, erro, dado_Lido, lat);
        @(posedge clock); #1;
        chk("pronto_pulse", {31'b0, pronto}, 32'h0);
        chk("ocupado_idle", {31'b0, ocupado}, 32'h0);
        if (o <= LBU || e_exp) chk("dado_Lido_hold", dado_Lido, rd_exp);
    endtask

    initial begin
        int          w0;
        int          pulses;
        logic        e_exp;
        logic [31:0] rd_exp;
        int          lat_exp;
        int          nw_exp;
        logic [31:0] a;
        logic [2:0]  o;

        for (int i = 0; i < PROF; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        reset = 1'b1; req = 1'b0; op = 3'd0; endereco = '0; dado_Escrito = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_pronto", {31'b0, pronto}, 32'h0);
        chk("rst_erro", {31'b0, erro}, 32'h0);
        chk("rst_ocupado", {31'b0, ocupado}, 32'h0);
        chk("rst_dado_Lido", dado_Lido, 32'h0);
        chk("rst_mem_endereco", {6'b0, mem_endereco}, 32'h0);
        chk("rst_memWrite", {31'b0, mem_memWrite}, 32'h0);
        chk("rst_mem_dado", mem_dado_Escrito, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        do_op(SW, 32'h08, 32'hDEADBEEF);
        chk("sw_word_index", {6'b0, last_wr}, 32'd2);
        do_op(LW, 32'h08, 32'h0);
        do_op(SB, 32'h09, 32'hAAAAAA55);
        do_op(LW, 32'h08, 32'h0);
        do_op(LB, 32'h08, 32'h0);
        do_op(LBU, 32'h08, 32'h0);
        do_op(LH, 32'h0A, 32'h0);
        do_op(LHU, 32'h0A, 32'h0);
        chk("merged_word", mem[2], 32'hDE55BEEF);
        do_op(LW, 32'h06, 32'h0);
        do_op(SH, 32'h03, 32'h1234);
        do_op(SW, 32'(PROF * 4), 32'h12345678);
        do_op(SH, 32'hF000_0010, 32'h0000_CAFE);
        do_op(LB, 32'h7C, 32'h0);

        // Reset asserted while SH is in its write cycle.
        @(negedge clock);
        req = 1'b1; op = SH; endereco = 32'h14; dado_Escrito = 32'h0000_1234;
        w0 = n_writes;
        @(posedge clock); #1;
        req = 1'b0;
        @(posedge clock); #1;
        chk("sh_in_write", {31'b0, ocupado}, 32'h1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_mid_writes", 32'(n_writes - w0), 32'h0);
        chk("rst_mid_mem", mem[5], ref_mem[5]);
        chk("rst_mid_ocupado", {31'b0, ocupado}, 32'h0);
        chk("rst_mid_pronto", {31'b0, pronto}, 32'h0);
        chk("rst_mid_dado", dado_Lido, 32'h0);
        chk("rst_mid_addr", {6'b0, mem_endereco}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(posedge clock); #1;
            if (pronto) pulses++;
        end
        chk("rst_mid_no_pronto", 32'(pulses), 32'h0);

        // A second req while busy must be dropped.
        model(LW, 32'h08, 32'h0, e_exp, rd_exp, lat_exp, nw_exp);
        @(negedge clock);
        req = 1'b1; op = LW; endereco = 32'h08;
        w0 = n_writes;
        @(posedge clock); #1;
        req = 1'b0;
        @(negedge clock);
        req = 1'b1; op = SW; endereco = 32'h0C; dado_Escrito = 32'h0BADF00D;
        @(posedge clock); #1;
        req = 1'b0;
        pulses = pronto ? 1 : 0;
        chk("busy_dado_Lido", dado_Lido, rd_exp);
        repeat (6) begin
            @(posedge clock); #1;
            if (pronto) pulses++;
        end
        chk("busy_pulses", 32'(pulses), 32'd1);
        chk("busy_writes", 32'(n_writes - w0), 32'h0);
        $display("busy-drop test: pronto pulses=%0d", pulses);

        for (int i = 0; i < 80; i++) begin
            o = 3'($urandom_range(0, 7));
            a = ($urandom & 32'hF000_0000) | 32'($urandom_range(0, PROF * 4 + 12));
            do_op(o, a, $urandom);
        end

        for (int i = 0; i < PROF; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
